// File: rtl/adder_share_arbiter.sv
// Round-robin scheduler time-multiplexing one combinational FP adder among NUM_REQ requesters.
// Optional grant/stall counters are built when ADDER_ARB_STATS_EN is defined.
`ifndef DATA_PRECISION
`define DATA_PRECISION 32
`endif

module adder_share_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int TAG_WIDTH = 8,
    parameter int ID_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_REQ-1:0]                       req_valid,
    output logic [NUM_REQ-1:0]                       req_ready,
    input  logic [NUM_REQ-1:0][`DATA_PRECISION-1:0]  req_ax,
    input  logic [NUM_REQ-1:0][`DATA_PRECISION-1:0]  req_ay,
    input  logic [NUM_REQ-1:0][TAG_WIDTH-1:0]        req_tag,
    output logic [`DATA_PRECISION-1:0]               add_ax,
    output logic [`DATA_PRECISION-1:0]               add_ay,
    input  logic [`DATA_PRECISION-1:0]               add_result,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [`DATA_PRECISION-1:0]               out_result,
    output logic [ID_WIDTH-1:0]                      out_id,
    output logic [TAG_WIDTH-1:0]                     out_tag,
    output logic [31:0]                              stat_grants,
    output logic [31:0]                              stat_stalls
);

    localparam int DW = `DATA_PRECISION;

    logic                 s1_valid;
    logic [DW-1:0]        s1_ax;
    logic [DW-1:0]        s1_ay;
    logic [ID_WIDTH-1:0]  s1_id;
    logic [TAG_WIDTH-1:0] s1_tag;

    logic                 s2_valid;
    logic [DW-1:0]        s2_result;
    logic [ID_WIDTH-1:0]  s2_id;
    logic [TAG_WIDTH-1:0] s2_tag;

    logic [ID_WIDTH-1:0]  rr_ptr;
    logic [ID_WIDTH-1:0]  ptr_next;
    logic [ID_WIDTH-1:0]  grant_idx;
    logic                 grant_found;
    logic                 handshake;
    logic                 s2_load;
    logic                 s1_free;

    assign s2_load   = s1_valid & (~s2_valid | out_ready);
    assign s1_free   = ~s1_valid | s2_load;
    assign handshake = grant_found & s1_free;

    // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                grant_found = 1'b1;
                grant_idx   = ID_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign ptr_next = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + ID_WIDTH'(1);

    always_comb begin
        req_ready = '0;
        if (handshake) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_ax    <= '0;
            s1_ay    <= '0;
            s1_id    <= '0;
            s1_tag   <= '0;
            rr_ptr   <= '0;
        end else if (handshake) begin
            s1_valid <= 1'b1;
            s1_ax    <= req_ax[grant_idx];
            s1_ay    <= req_ay[grant_idx];
            s1_id    <= grant_idx;
            s1_tag   <= req_tag[grant_idx];
            rr_ptr   <= ptr_next;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // S2 captures the adder output one cycle after the operands settle in S1.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_id     <= '0;
            s2_tag    <= '0;
        end else if (s2_load) begin
            s2_valid  <= 1'b1;
            s2_result <= add_result;
            s2_id     <= s1_id;
            s2_tag    <= s1_tag;
        end else if (out_ready) begin
            s2_valid  <= 1'b0;
        end
    end

    assign add_ax     = s1_ax;
    assign add_ay     = s1_ay;
    assign out_valid  = s2_valid;
    assign out_result = s2_result;
    assign out_id     = s2_id;
    assign out_tag    = s2_tag;

`ifdef ADDER_ARB_STATS_EN
    logic [31:0] grants_cnt;
    logic [31:0] stalls_cnt;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            grants_cnt <= '0;
            stalls_cnt <= '0;
        end else begin
            if (handshake && (grants_cnt != 32'hFFFF_FFFF)) begin
                grants_cnt <= grants_cnt + 32'd1;
            end
            if (s2_valid && !out_ready && (stalls_cnt != 32'hFFFF_FFFF)) begin
                stalls_cnt <= stalls_cnt + 32'd1;
            end
        end
    end

    assign stat_grants = grants_cnt;
    assign stat_stalls = stalls_cnt;
`else
    assign stat_grants = '0;
    assign stat_stalls = '0;
`endif

endmodule

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Round-robin scheduler that shares one combinational FP adder (`single_adder_comb` / `DW_fp_add`) among `NUM_REQ` requesters in the SpMV merge datapath. It registers the granted operand pair, drives the shared adder, and captures the sum. It returns the result with the requester ID and a pass-through tag over a valid/ready output channel with full backpressure. The block sits between the merge-tree lanes and the single adder instance, so several lanes can time-multiplex one FP adder.

## Interface
- `NUM_REQ`, default 4: number of requesters; must be ≥2.
- `TAG_WIDTH`, default 8: width of the opaque tag carried with each request.
- `ID_WIDTH`, default `$clog2(NUM_REQ)`: requester-ID width.
- Data width is `` `DATA_PRECISION `` from `definitions.vh`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in `NUM_REQ`: per-requester request valid.
- `req_ready` out `NUM_REQ`: per-requester accept; at most one bit high per cycle.
- `req_ax`, `req_ay` in `NUM_REQ` x `DATA_PRECISION`: operand pairs.
- `req_tag` in `NUM_REQ` x `TAG_WIDTH`: tags.
- `add_ax`, `add_ay` out `DATA_PRECISION`: to the shared adder inputs.
- `add_result` in `DATA_PRECISION`: from the shared adder output (combinational).
- `out_valid` out 1; `out_ready` in 1: result channel.
- `out_result` out `DATA_PRECISION`; `out_id` out `ID_WIDTH`; `out_tag` out `TAG_WIDTH`.
- `stat_grants`, `stat_stalls` out 32: performance counters; see Configuration.

## Operation
- Two register stages:
  - S1 (operand): `s1_valid`, ax, ay, id, tag.
  - S2 (result): `s2_valid`, result, id, tag.
- `add_ax`/`add_ay` are driven directly from the S1 registers. `add_result` is captured into S2.
- Advance rules:
  - `s2_load = s1_valid & (!s2_valid | out_ready)`
  - `s1_free = !s1_valid | s2_load`
- Arbiter:
  - Round-robin pointer `rr_ptr`. The grant goes to the first requester with `req_valid` set, searching from `rr_ptr` upward modulo `NUM_REQ`.
  - `req_ready[g]=1` only for the granted `g`, and only when `s1_free`. All other bits are 0.
- Handshake: on `req_valid[g] & req_ready[g]`, S1 loads requester `g`'s operands, tag and ID `g`; `rr_ptr` becomes `(g+1) mod NUM_REQ`.
- No handshake means `rr_ptr` holds. No request is ever dropped or duplicated.
- Requester rules:
  - Once `req_valid[i]` is asserted, the requester holds it and its data stable until accepted.
  - `req_valid` must not depend on `req_ready`.
- Output: `out_valid = s2_valid`; result fields come from S2. A result completes when `out_valid & out_ready`.
- Results leave in grant order. No reordering.
- The adder is treated as purely combinational; its setup window is one cycle from S1 to S2.
- Reset state:
  - `s1_valid=0`, `s2_valid=0`, `rr_ptr=0`.
  - `req_ready=0`, `out_valid=0`.
  - `out_result`, `out_id`, `out_tag` = 0; stats = 0.
- Reset mid-operation discards S1 and S2 contents. Requesters must re-present their requests.

## Timing
- Latency: request accepted at the end of cycle t gives `out_valid=1` in cycle t+2 if `out_ready` was not low.
- Throughput: one result per cycle when `out_ready=1` continuously.
- Output backpressure:
  - With `out_ready=0` and S2 full, S1 holds.
  - If S1 is also full, all `req_ready` bits are 0.
  - Maximum of two results are in flight.
- Simultaneous `out_ready` handshake and S1 advance in the same cycle: S2 reloads from S1 with no bubble.
- Outputs hold stable while `out_valid & !out_ready`.
- `req_ready` is combinational from `req_valid`, `rr_ptr` and stage occupancy. It is not registered.

## Configuration
- Macro: `ADDER_ARB_STATS_EN`.
- Defined:
  - `stat_grants` increments on every request handshake.
  - `stat_stalls` increments every cycle with `out_valid & !out_ready`.
  - Both are 32-bit, saturate at `0xFFFFFFFF`, and clear on `rst`.
- Undefined: counters are not built, and `stat_grants`/`stat_stalls` are tied to 0.

## Test plan
- Single request, FP32: requester 2 sends ax=0x3F800000, ay=0x40000000, tag=0x5A, with `out_ready=1`. Required: `out_valid` exactly 2 cycles after the handshake, `out_result`=0x40400000, `out_id`=2, `out_tag`=0x5A.
- All 4 requesters valid continuously, `out_ready=1`. Required: grants in order 0,1,2,3,0,…, one per cycle, and results return with `out_id` in the same order.
- Backpressure: hold `out_ready=0` for 5 cycles with all requesters valid. Required: exactly 2 handshakes, then all `req_ready=0`. Outputs stay stable. After release, there are no lost or duplicated tags.
- Sparse valids: only requesters 1 and 3 are valid and `rr_ptr`=2. Required: grant 3, then 1, then 3.
- Reset mid-flight: assert `rst` for 1 cycle with S1 and S2 both full. Required: next cycle `out_valid=0`, `rr_ptr=0`, and stats read 0.
- With `ADDER_ARB_STATS_EN` defined: 10 handshakes and 3 stall cycles give `stat_grants`=10 and `stat_stalls`=3. Undefined: both read 0.
